// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - button conditioner pin/game-side signal bundle
// Groups raw button inputs, repeat enable and conditioned outputs.
interface btn_conditioner_if;
  logic btnU_raw;
  logic btnD_raw;
  logic btnS_raw;
  logic repeat_en;
  logic btnU;
  logic btnD;
  logic btnS;
  logic btnU_level;
  logic btnD_level;
  logic btnS_level;
  logic long_s;

  modport master (
    output btnU_raw, btnD_raw, btnS_raw, repeat_en,
    input  btnU, btnD, btnS, btnU_level, btnD_level, btnS_level, long_s
  );

  modport slave (
    input  btnU_raw, btnD_raw, btnS_raw, repeat_en,
    output btnU, btnD, btnS, btnU_level, btnD_level, btnS_level, long_s
  );
endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounce, press pulse, auto-repeat and long-press for U/D/S
// Index 0 = up, 1 = down, 2 = select throughout.
module btn_conditioner #(
  parameter int DEB_TICKS    = 2,
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_RATE  = 4,
  parameter int LONG_TICKS   = 40,
  parameter int HOLD_W       = 6
) (
  input  logic               clk_20Hz,
  input  logic               rst,
  btn_conditioner_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  localparam logic [HOLD_W-1:0] DEB_C      = HOLD_W'(DEB_TICKS);
  localparam logic [HOLD_W-1:0] REP_DLY_C  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] REP_RATE_C = HOLD_W'(REPEAT_RATE);
  localparam logic [HOLD_W-1:0] LONG_C     = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = '1;

  logic [2:0]        raw;
  logic [2:0]        s1_q, s1_d, s2_q, s2_d;
  state_t            state_q [3];
  state_t            state_d [3];
  logic [HOLD_W-1:0] deb_cnt_q [3];
  logic [HOLD_W-1:0] deb_cnt_d [3];
  logic [HOLD_W-1:0] hold_cnt_q [3];
  logic [HOLD_W-1:0] hold_cnt_d [3];
  logic [HOLD_W-1:0] rpt_cnt_q [3];
  logic [HOLD_W-1:0] rpt_cnt_d [3];
  logic [2:0]        pulse_q, pulse_d, level_q, level_d;
  logic              long_q, long_d;
  logic [HOLD_W-1:0] hold_inc;
  logic              fresh;
  logic              both_held;

  assign raw       = {bus.btnS_raw, bus.btnD_raw, bus.btnU_raw};
  assign both_held = level_q[0] & level_q[1];

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    pulse_d  = '0;
    level_d  = level_q;
    long_d   = 1'b0;
    hold_inc = '0;
    fresh    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      state_d[i]    = state_q[i];
      deb_cnt_d[i]  = deb_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      rpt_cnt_d[i]  = rpt_cnt_q[i];
      hold_inc      = (hold_cnt_q[i] == HOLD_MAX) ? hold_cnt_q[i] : hold_cnt_q[i] + 1'b1;
      // fresh guards one-shot events against re-firing once hold_cnt saturates
      fresh         = (hold_inc != hold_cnt_q[i]);
      case (state_q[i])
        IDLE: begin
          if (s2_q[i]) begin
            if (DEB_TICKS == 1) begin
              state_d[i]    = HELD;
              pulse_d[i]    = 1'b1;
              level_d[i]    = 1'b1;
              hold_cnt_d[i] = '0;
              rpt_cnt_d[i]  = '0;
            end else begin
              state_d[i]   = CONFIRM;
              deb_cnt_d[i] = 1;
            end
          end
        end
        CONFIRM: begin
          if (s2_q[i]) begin
            deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            if (deb_cnt_d[i] == DEB_C) begin
              state_d[i]    = HELD;
              pulse_d[i]    = 1'b1;
              level_d[i]    = 1'b1;
              hold_cnt_d[i] = '0;
              rpt_cnt_d[i]  = '0;
            end
          end else begin
            state_d[i]   = IDLE;
            deb_cnt_d[i] = '0;
          end
        end
        HELD: begin
          if (s2_q[i]) begin
            hold_cnt_d[i] = hold_inc;
            if (i != 2 && bus.repeat_en && !both_held) begin
              if (fresh && hold_inc == REP_DLY_C) begin
                pulse_d[i]   = 1'b1;
                rpt_cnt_d[i] = '0;
              end else if (hold_inc > REP_DLY_C) begin
                rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                if (rpt_cnt_d[i] == REP_RATE_C) begin
                  pulse_d[i]   = 1'b1;
                  rpt_cnt_d[i] = '0;
                end
              end
            end else begin
              rpt_cnt_d[i] = '0;
            end
            if (i == 2 && fresh && hold_inc == LONG_C) begin
              long_d = 1'b1;
            end
          end else if (DEB_TICKS == 1) begin
            state_d[i]    = IDLE;
            level_d[i]    = 1'b0;
            hold_cnt_d[i] = '0;
            rpt_cnt_d[i]  = '0;
          end else begin
            state_d[i]   = RELEASE;
            deb_cnt_d[i] = 1;
            rpt_cnt_d[i] = '0;
          end
        end
        RELEASE: begin
          if (!s2_q[i]) begin
            deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            if (deb_cnt_d[i] == DEB_C) begin
              state_d[i]    = IDLE;
              level_d[i]    = 1'b0;
              deb_cnt_d[i]  = '0;
              hold_cnt_d[i] = '0;
            end
          end else begin
            state_d[i]   = HELD;
            deb_cnt_d[i] = '0;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_20Hz or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pulse_q <= '0;
      level_q <= '0;
      long_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i]    <= IDLE;
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
        rpt_cnt_q[i]  <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      long_q  <= long_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i]    <= state_d[i];
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        rpt_cnt_q[i]  <= rpt_cnt_d[i];
      end
    end
  end

  assign bus.btnU       = pulse_q[0];
  assign bus.btnD       = pulse_q[1];
  assign bus.btnS       = pulse_q[2];
  assign bus.btnU_level = level_q[0];
  assign bus.btnD_level = level_q[1];
  assign bus.btnS_level = level_q[2];
  assign bus.long_s     = long_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - table-driven and sequence checks for btn_conditioner
// Output word: {btnS, btnD, btnU, S_level, D_level, U_level, long_s}.
module tb_btn_conditioner;

  logic clk_20Hz = 1'b0;
  logic rst;

  btn_conditioner_if bus ();

  btn_conditioner dut (
    .clk_20Hz (clk_20Hz),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_20Hz = ~clk_20Hz;

  typedef struct {
    logic [2:0] raw;
    logic       rep;
    logic [2:0] pulse;
    logic [2:0] level;
    logic       lng;
  } vec_t;

  vec_t       vq[$];
  logic [6:0] trace[$];
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.btnS, bus.btnD, bus.btnU, bus.btnS_level, bus.btnD_level, bus.btnU_level, bus.long_s};
  endfunction

  task automatic drive(input logic [2:0] raw, input logic rep);
    bus.btnU_raw  = raw[0];
    bus.btnD_raw  = raw[1];
    bus.btnS_raw  = raw[2];
    bus.repeat_en = rep;
  endtask

  task automatic add(input logic [2:0] raw, input logic rep, input logic [2:0] p,
                     input logic [2:0] l, input logic lng, input int n);
    vec_t v;
    v.raw = raw; v.rep = rep; v.pulse = p; v.level = l; v.lng = lng;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic run_hold(input logic [2:0] raw, input logic rep, input int hold_ticks, input int total);
    trace.delete();
    for (int k = 0; k < total; k++) begin
      drive((k < hold_ticks) ? raw : 3'b000, rep);
      @(posedge clk_20Hz);
      @(negedge clk_20Hz);
      trace.push_back(outs());
    end
  endtask

  function automatic logic [63:0] mask_of(input int b);
    logic [63:0] m = '0;
    for (int k = 0; k < trace.size() && k < 64; k++)
      if (trace[k][b]) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bit_at(input int n);
    return 64'(1) << n;
  endfunction

  initial begin
    drive(3'b000, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk_20Hz);
    check("reset_outputs", 64'(outs()), 64'd0);
    rst = 1'b0;

    // clean press and release of up
    add(3'b001, 0, 3'b000, 3'b000, 0, 3);
    add(3'b001, 0, 3'b001, 3'b001, 0, 1);
    add(3'b001, 0, 3'b000, 3'b001, 0, 1);
    add(3'b000, 0, 3'b000, 3'b001, 0, 3);
    add(3'b000, 0, 3'b000, 3'b000, 0, 2);
    // one-tick release glitch keeps level, gives no new pulse
    add(3'b001, 1, 3'b000, 3'b000, 0, 3);
    add(3'b001, 1, 3'b001, 3'b001, 0, 1);
    add(3'b000, 1, 3'b000, 3'b001, 0, 1);
    add(3'b001, 1, 3'b000, 3'b001, 0, 4);
    add(3'b000, 1, 3'b000, 3'b001, 0, 3);
    add(3'b000, 1, 3'b000, 3'b000, 0, 2);
    // select bounce: three single-tick pulses
    for (int r = 0; r < 3; r++) begin
      add(3'b100, 0, 3'b000, 3'b000, 0, 1);
      add(3'b000, 0, 3'b000, 3'b000, 0, 1);
    end
    add(3'b000, 0, 3'b000, 3'b000, 0, 3);
    // down and select together
    add(3'b110, 0, 3'b000, 3'b000, 0, 3);
    add(3'b110, 0, 3'b110, 3'b110, 0, 1);
    add(3'b000, 0, 3'b000, 3'b110, 0, 3);
    add(3'b000, 0, 3'b000, 3'b000, 0, 2);

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].raw, vq[k].rep);
      @(posedge clk_20Hz);
      @(negedge clk_20Hz);
      check($sformatf("vec%0d", k), 64'(outs()),
            64'({vq[k].pulse, vq[k].level, vq[k].lng}));
    end

    run_hold(3'b010, 1'b1, 30, 40);
    check("d_repeat_pulses", mask_of(5),
          bit_at(3) | bit_at(13) | bit_at(17) | bit_at(21) | bit_at(25) | bit_at(29));
    check("d_repeat_no_u", mask_of(4), 64'd0);

    run_hold(3'b010, 1'b0, 30, 40);
    check("d_norepeat_pulses", mask_of(5), bit_at(3));
    check("d_norepeat_level", mask_of(2), 64'h1_FFFF_FFF8);

    for (int r = 0; r < 2; r++) begin
      run_hold(3'b100, 1'b1, 50, 58);
      check($sformatf("s_long_press%0d", r), mask_of(6), bit_at(3));
      check($sformatf("s_long_event%0d", r), mask_of(0), bit_at(43));
    end

    run_hold(3'b011, 1'b1, 30, 36);
    check("ud_u_pulses", mask_of(4), bit_at(3));
    check("ud_d_pulses", mask_of(5), bit_at(3));

    // reset arriving mid-hold, button still held afterwards
    run_hold(3'b001, 1'b0, 9, 9);
    check("rst_pre_level", 64'(bus.btnU_level), 64'd1);
    #1 rst = 1'b1;
    #1 check("rst_async_clear", 64'(outs()), 64'd0);
    @(negedge clk_20Hz);
    check("rst_held_clear", 64'(outs()), 64'd0);
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk_20Hz);
      @(negedge clk_20Hz);
      check($sformatf("rst_repress_e%0d", e), 64'(bus.btnU), 64'(e == 4));
    end
    run_hold(3'b000, 1'b0, 0, 8);
    check("rst_final_idle", 64'(outs()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
